// File: rtl/ooo_pkg.sv
// ooo_pkg: shared out-of-order core widths, FU encodings and reservation-station types
package ooo_pkg;
   localparam int ROB_SIZE_BITS = 4;
   localparam int PREG_BITS = 6;
   localparam int PAYLOAD_W = 64;
   localparam logic [1:0] FU_ALU = 2'd0;
   localparam logic [1:0] FU_MEM = 2'd1;
   typedef struct packed {
      logic valid;
      logic [1:0] fu;
      logic [PREG_BITS-1:0] src1_tag;
      logic [PREG_BITS-1:0] src2_tag;
      logic src1_rdy;
      logic src2_rdy;
      logic [ROB_SIZE_BITS-1:0] rob;
      logic [PAYLOAD_W-1:0] payload;
   } rsEntry;
   typedef struct packed {
      logic alu1;
      logic alu2;
      logic mem;
   } fuRdyStruct;
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: one-hot oldest and second-oldest requester; smaller age is older, ties go to the lower index
module rs_age_select #(
   parameter int N = 16,
   parameter int AW = 4
) (
   input logic [N-1:0] req,
   input logic [N*AW-1:0] age,
   output logic [N-1:0] oldest,
   output logic oldest_valid,
   output logic [N-1:0] second,
   output logic second_valid
);
   localparam int CW = $clog2(N + 1);
   logic [CW-1:0] rank [N];
   // rank = number of requesters strictly older than entry i
   always_comb begin
      for (int i = 0; i < N; i++) begin
         rank[i] = '0;
         for (int j = 0; j < N; j++)
            rank[i] = rank[i] + CW'(req[j] && (age[j*AW +: AW] < age[i*AW +: AW] || (age[j*AW +: AW] == age[i*AW +: AW] && j < i)));
         oldest[i] = req[i] && rank[i] == '0;
         second[i] = req[i] && rank[i] == CW'(1);
      end
   end
   assign oldest_valid = |oldest;
   assign second_valid = |second;
endmodule

// File: rtl/rs_issue_scheduler.sv
// rs_issue_scheduler: unified reservation station issuing oldest-ready ops to ALU1, ALU2 and MEM
// Define RS_BYPASS_WAKEUP_EN to let same-cycle wakeups feed selection combinationally
module rs_issue_scheduler #(
   parameter int RS_DEPTH = 16,
   parameter int ROB_SIZE_BITS = 4,
   parameter int PREG_BITS = 6,
   parameter int PAYLOAD_W = 64
) (
   input logic clk,
   input logic reset,
   input logic flush,
   input logic [ROB_SIZE_BITS-1:0] rob_head,
   input logic disp0_valid,
   input logic [1:0] disp0_fu,
   input logic [PREG_BITS-1:0] disp0_src1_tag,
   input logic [PREG_BITS-1:0] disp0_src2_tag,
   input logic disp0_src1_rdy,
   input logic disp0_src2_rdy,
   input logic [ROB_SIZE_BITS-1:0] disp0_rob,
   input logic [PAYLOAD_W-1:0] disp0_payload,
   input logic disp1_valid,
   input logic [1:0] disp1_fu,
   input logic [PREG_BITS-1:0] disp1_src1_tag,
   input logic [PREG_BITS-1:0] disp1_src2_tag,
   input logic disp1_src1_rdy,
   input logic disp1_src2_rdy,
   input logic [ROB_SIZE_BITS-1:0] disp1_rob,
   input logic [PAYLOAD_W-1:0] disp1_payload,
   output logic disp_ready,
   output logic [$clog2(RS_DEPTH+1)-1:0] free_count,
   input logic wb0_valid,
   input logic [PREG_BITS-1:0] wb0_tag,
   input logic wb1_valid,
   input logic [PREG_BITS-1:0] wb1_tag,
   input logic fu_rdy_alu1,
   input logic fu_rdy_alu2,
   input logic fu_rdy_mem,
   output logic alu1_issue_valid,
   output logic [ROB_SIZE_BITS-1:0] alu1_issue_rob,
   output logic [PAYLOAD_W-1:0] alu1_issue_payload,
   output logic alu2_issue_valid,
   output logic [ROB_SIZE_BITS-1:0] alu2_issue_rob,
   output logic [PAYLOAD_W-1:0] alu2_issue_payload,
   output logic mem_issue_valid,
   output logic [ROB_SIZE_BITS-1:0] mem_issue_rob,
   output logic [PAYLOAD_W-1:0] mem_issue_payload
);
   import ooo_pkg::*;
   localparam int CW = $clog2(RS_DEPTH + 1);
   rsEntry ent [RS_DEPTH];
   rsEntry new0, new1;
   fuRdyStruct fu_rdy;
   logic [RS_DEPTH-1:0] w1, w2, elig, alu_req, mem_req, sel0, sel1, issued;
   logic [RS_DEPTH-1:0] a_old, a_sec, m_old, m_sec_unused, alu1_pick, alu2_pick, mem_pick;
   logic [RS_DEPTH*ROB_SIZE_BITS-1:0] age;
   logic a_old_v, a_sec_v, m_old_v, m_sec_v_unused, alu1_go, alu2_go, mem_go, got0, got1;
   logic [ROB_SIZE_BITS-1:0] alu1_rob_n, alu2_rob_n, mem_rob_n;
   logic [PAYLOAD_W-1:0] alu1_pay_n, alu2_pay_n, mem_pay_n;

   function automatic logic woken(input logic rdy, input logic [PREG_BITS-1:0] tag);
      return rdy | (wb0_valid && wb0_tag == tag) | (wb1_valid && wb1_tag == tag);
   endfunction

   assign fu_rdy = {fu_rdy_alu1, fu_rdy_alu2, fu_rdy_mem};

   always_comb begin
      free_count = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         w1[i] = woken(ent[i].src1_rdy, ent[i].src1_tag);
         w2[i] = woken(ent[i].src2_rdy, ent[i].src2_tag);
`ifdef RS_BYPASS_WAKEUP_EN
         elig[i] = ent[i].valid && w1[i] && w2[i];
`else
         elig[i] = ent[i].valid && ent[i].src1_rdy && ent[i].src2_rdy;
`endif
         alu_req[i] = elig[i] && ent[i].fu != FU_MEM;
         mem_req[i] = elig[i] && ent[i].fu == FU_MEM;
         age[i*ROB_SIZE_BITS +: ROB_SIZE_BITS] = ent[i].rob - rob_head;
         free_count = free_count + CW'(!ent[i].valid);
      end
   end

   rs_age_select #(.N(RS_DEPTH), .AW(ROB_SIZE_BITS)) u_alu_sel (
      .req(alu_req), .age(age), .oldest(a_old), .oldest_valid(a_old_v), .second(a_sec), .second_valid(a_sec_v)
   );
   rs_age_select #(.N(RS_DEPTH), .AW(ROB_SIZE_BITS)) u_mem_sel (
      .req(mem_req), .age(age), .oldest(m_old), .oldest_valid(m_old_v), .second(m_sec_unused), .second_valid(m_sec_v_unused)
   );

   // with a single ALU ready, it takes the oldest regardless of which unit it is
   assign alu1_go = fu_rdy.alu1 && a_old_v;
   assign alu2_go = fu_rdy.alu2 && (fu_rdy.alu1 ? a_sec_v : a_old_v);
   assign mem_go = fu_rdy.mem && m_old_v;
   assign alu1_pick = alu1_go ? a_old : '0;
   assign alu2_pick = alu2_go ? (fu_rdy.alu1 ? a_sec : a_old) : '0;
   assign mem_pick = mem_go ? m_old : '0;
   assign issued = alu1_pick | alu2_pick | mem_pick;
   assign disp_ready = free_count >= CW'(2);

   assign new0 = '{valid: 1'b1, fu: disp0_fu, src1_tag: disp0_src1_tag, src2_tag: disp0_src2_tag,
                   src1_rdy: woken(disp0_src1_rdy, disp0_src1_tag), src2_rdy: woken(disp0_src2_rdy, disp0_src2_tag),
                   rob: disp0_rob, payload: disp0_payload};
   assign new1 = '{valid: 1'b1, fu: disp1_fu, src1_tag: disp1_src1_tag, src2_tag: disp1_src2_tag,
                   src1_rdy: woken(disp1_src1_rdy, disp1_src1_tag), src2_rdy: woken(disp1_src2_rdy, disp1_src2_tag),
                   rob: disp1_rob, payload: disp1_payload};

   always_comb begin
      alu1_rob_n = '0;
      alu2_rob_n = '0;
      mem_rob_n = '0;
      alu1_pay_n = '0;
      alu2_pay_n = '0;
      mem_pay_n = '0;
      sel0 = '0;
      sel1 = '0;
      got0 = 1'b0;
      got1 = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         alu1_rob_n |= alu1_pick[i] ? ent[i].rob : '0;
         alu2_rob_n |= alu2_pick[i] ? ent[i].rob : '0;
         mem_rob_n |= mem_pick[i] ? ent[i].rob : '0;
         alu1_pay_n |= alu1_pick[i] ? ent[i].payload : '0;
         alu2_pay_n |= alu2_pick[i] ? ent[i].payload : '0;
         mem_pay_n |= mem_pick[i] ? ent[i].payload : '0;
         sel1[i] = !ent[i].valid && got0 && !got1;
         got1 = got1 | sel1[i];
         sel0[i] = !ent[i].valid && !got0;
         got0 = got0 | sel0[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         for (int i = 0; i < RS_DEPTH; i++) ent[i].valid <= 1'b0;
         alu1_issue_valid <= 1'b0;
         alu2_issue_valid <= 1'b0;
         mem_issue_valid <= 1'b0;
         alu1_issue_rob <= '0;
         alu2_issue_rob <= '0;
         mem_issue_rob <= '0;
         alu1_issue_payload <= '0;
         alu2_issue_payload <= '0;
         mem_issue_payload <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            ent[i].src1_rdy <= w1[i];
            ent[i].src2_rdy <= w2[i];
            if (issued[i]) ent[i].valid <= 1'b0;
            if (disp0_valid && sel0[i]) ent[i] <= new0;
            if (disp1_valid && sel1[i]) ent[i] <= new1;
         end
         alu1_issue_valid <= alu1_go;
         alu2_issue_valid <= alu2_go;
         mem_issue_valid <= mem_go;
         alu1_issue_rob <= alu1_rob_n;
         alu2_issue_rob <= alu2_rob_n;
         mem_issue_rob <= mem_rob_n;
         alu1_issue_payload <= alu1_pay_n;
         alu2_issue_payload <= alu2_pay_n;
         mem_issue_payload <= mem_pay_n;
      end
   end
endmodule
